credit_tx_gate: RTL
===================

Name: credit_tx_gate

Overview:
Transmit-side credit gate for credit-flow-controlled links. It holds a local count of downstream buffer credits. It forwards an input valid/ready stream onto a link that has no backpressure, and spends one credit per beat. Credits returned by the receiver restore the count, in single or bulk returns. It sits between a producer FIFO and the link serializer, and pairs with the receiver's occupancy counter on the far end.

Parameters:
DATA_WIDTH, 64, payload width of each beat.
CREDIT_WIDTH, 8, width of credit counter and credits_avail output; must satisfy 2^CREDIT_WIDTH > MAX_CREDITS.
MAX_CREDITS, 16, receiver buffer depth; credit count loaded at init.
RET_WIDTH, 4, width of bulk credit-return count.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  producer beat valid
in_data  in  DATA_WIDTH  producer payload
in_ready  out  1  gate accepts beat this cycle
out_valid  out  1  beat launched on link (no backpressure)
out_data  out  DATA_WIDTH  launched payload
credit_ret_valid  in  1  receiver returns credits this cycle
credit_ret_count  in  RET_WIDTH  number of credits returned (0 legal, no-op)
credits_avail  out  CREDIT_WIDTH  current credit count
init_done  out  1  gate has completed init and is in RUN
overflow_err  out  1  sticky: credit count exceeded MAX_CREDITS

Behaviour:
- Reset: rst synchronous, active-high; clock clk. While rst is high: state=INIT, credits=0, out_valid=0, out_data=0, in_ready=0, init_done=0, overflow_err=0. Reset mid-operation discards any in-flight beat and all credits.
- FSM INIT: one cycle after rst deasserts. Loads credits=MAX_CREDITS and moves to RUN. Credit returns during INIT are ignored.
- FSM RUN: init_done=1. in_ready = (credits != 0), combinational from the registered count. A credit returned in the same cycle is not bypassed into in_ready.
- Accept: in_valid & in_ready. The next cycle has out_valid=1 and out_data=in_data, so latency is exactly 1 cycle. Otherwise out_valid=0 the next cycle, and out_data holds its last value.
- Credit update, each RUN cycle: next = credits − accept + (credit_ret_valid ? credit_ret_count : 0). Compute it at CREDIT_WIDTH+1 bits, with no wrap.
- Simultaneous accept and return are both applied in the same cycle. A return of N while accepting gives a net change of N−1.
- Underflow cannot occur, because accept requires credits ≥ 1.
- Overflow: if next > MAX_CREDITS, set overflow_err=1, clamp credits=MAX_CREDITS, and go to ERROR. The accept in that cycle still completes and its beat is launched.
- FSM ERROR: in_ready=0 and init_done=0. out_valid follows the normal 1-cycle rule, so a beat accepted in the error cycle appears, then out_valid=0. Credits are frozen and returns are ignored. Exit is by rst only.
- credits_avail always reflects the registered count.

Test Plan:
- Reset then idle: rst 3 cycles, release. Cycle 1 after: credits_avail=0, init_done=0. Cycle 2: credits_avail=16, init_done=1, in_ready=1.
- Drain: in_valid held high with data 0x1..0x10 for 20 cycles, no returns. Exactly 16 beats appear, each one cycle after acceptance, in order. in_ready=0 once credits_avail=0. Beats 17–20 are held off.
- Same-cycle return blocked: credits=0, in_valid=1, credit_ret_valid=1 with count=1. in_ready=0 that cycle; next cycle credits_avail=1 and in_ready=1.
- Simultaneous accept+return: credits=5, accept one beat, return count=3 in the same cycle. Next credits_avail=7.
- Overflow: credits=15, return count=4, no accept. overflow_err=1, credits_avail=16, in_ready=0, init_done=0. Further returns leave the count at 16. rst clears overflow_err and re-inits to 16.
- Reset mid-burst: assert rst the cycle after an accept. out_valid=0 on the next edge, credits_avail=0. After release, re-init to 16 and traffic resumes with no stale beat.

Source files
------------

// File: rtl/credit_tx_gate.sv
// Transmit-side credit gate: forwards a valid/ready stream onto a link without
// backpressure, spending one downstream buffer credit per launched beat.
module credit_tx_gate #(
    parameter int DATA_WIDTH   = 64,
    parameter int CREDIT_WIDTH = 8,
    parameter int MAX_CREDITS  = 16,
    parameter int RET_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    credit_ret_valid,
    input  logic [RET_WIDTH-1:0]    credit_ret_count,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    init_done,
    output logic                    overflow_err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [CREDIT_WIDTH:0]   MAX_WIDE   = (CREDIT_WIDTH+1)'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CNT    = CREDIT_WIDTH'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ZERO_CNT   = {CREDIT_WIDTH{1'b0}};
    localparam logic [CREDIT_WIDTH:0]   ZERO_WIDE  = {(CREDIT_WIDTH+1){1'b0}};
    localparam logic [DATA_WIDTH-1:0]   ZERO_DATA  = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CREDIT_WIDTH-1:0] credits_r;
    logic [CREDIT_WIDTH-1:0] credits_next_s;
    logic                    overflow_r;
    logic                    overflow_next_s;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    accept_s;
    logic [CREDIT_WIDTH:0]   ret_wide_s;
    logic [CREDIT_WIDTH:0]   credit_sum_s;

    // Readiness looks only at the registered count; a same-cycle return is not bypassed.
    assign in_ready      = (state_r == ST_RUN) && (credits_r != ZERO_CNT);
    assign accept_s      = in_valid & in_ready;
    assign init_done     = (state_r == ST_RUN);
    assign credits_avail = credits_r;
    assign overflow_err  = overflow_r;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;

    // Credit arithmetic one bit wider than the counter so an over-return is visible.
    always_comb begin
        ret_wide_s   = ZERO_WIDE;
        credit_sum_s = ZERO_WIDE;
        if (credit_ret_valid) begin
            ret_wide_s = (CREDIT_WIDTH+1)'(credit_ret_count);
        end else begin
            ret_wide_s = ZERO_WIDE;
        end
        credit_sum_s = {1'b0, credits_r} - (CREDIT_WIDTH+1)'(accept_s) + ret_wide_s;
    end

    // Next-state and credit/overflow update.
    always_comb begin
        state_next_s    = state_r;
        credits_next_s  = credits_r;
        overflow_next_s = overflow_r;
        case (state_r)
            ST_INIT: begin
                credits_next_s = MAX_CNT;
                state_next_s   = ST_RUN;
            end
            ST_RUN: begin
                if (credit_sum_s > MAX_WIDE) begin
                    overflow_next_s = 1'b1;
                    credits_next_s  = MAX_CNT;
                    state_next_s    = ST_ERROR;
                end else begin
                    credits_next_s  = credit_sum_s[CREDIT_WIDTH-1:0];
                end
            end
            ST_ERROR: begin
                state_next_s = ST_ERROR;
            end
            default: begin
                state_next_s   = ST_INIT;
                credits_next_s = ZERO_CNT;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            credits_r  <= ZERO_CNT;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            credits_r  <= credits_next_s;
            overflow_r <= overflow_next_s;
        end
    end

    // Launch register: accepted beat appears exactly one cycle later, data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= ZERO_DATA;
        end else begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_data_r <= in_data;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

endmodule
